sha512_thread_sched: RTL

//  Per-thread scheduler for the sha512crypt unit. Tracks the lifecycle of every thread slot:

---
 rtl/sha512_thread_sched.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sha512_thread_sched.sv
// Per-thread lifecycle scheduler for the sha512crypt unit: EMPTY -> READY -> BUSY -> DONE -> EMPTY.
// Issues READY threads in round-robin order and never lets two seq siblings be in flight together.
module sha512_thread_sched #(
  parameter int N_CORES   = 4,
  parameter int N_THREADS = 4 * N_CORES,
  localparam int TW = $clog2(N_THREADS),
  localparam int CW = $clog2(N_THREADS + 1)
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          load_valid,
  input  logic [TW-1:0] load_num,
  output logic          load_ready,
  output logic          issue_valid,
  output logic [TW-1:0] issue_num,
  input  logic          issue_ready,
  input  logic          done_valid,
  input  logic [TW-1:0] done_num,
  output logic          unload_valid,
  output logic [TW-1:0] unload_num,
  input  logic          unload_ready,
  output logic [CW-1:0] busy_count,
  output logic          err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    READY = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } thread_state_e;

  thread_state_e state_q [N_THREADS];
  thread_state_e state_d [N_THREADS];

  logic [TW-1:0] issuePtr_q, issuePtr_d;
  logic [TW-1:0] unloadPtr_q, unloadPtr_d;
  logic [CW-1:0] busyCount_q, busyCount_d;
  logic          err_q, err_d;

  logic loadNumOk, doneNumOk;
  logic loadFire, issueFire, doneFire, unloadFire;
  logic [TW-1:0] siblingNum;

  // Scan order walks core_ctx upward and flips seq on wrap, so siblings are half a lap apart.
  function automatic logic [TW-1:0] nextThread(input logic [TW-1:0] t);
    if (t[TW-1:1] == (TW-1)'(2 * N_CORES - 1))
      nextThread = {{(TW-1){1'b0}}, ~t[0]};
    else
      nextThread = {(TW-1)'(t[TW-1:1] + 1'b1), t[0]};
  endfunction

  assign loadNumOk  = (int'(load_num) < N_THREADS);
  assign doneNumOk  = (int'(done_num) < N_THREADS);
  assign siblingNum = {issuePtr_q[TW-1:1], ~issuePtr_q[0]};

  assign load_ready   = loadNumOk && (state_q[load_num] == EMPTY);
  assign issue_num    = issuePtr_q;
  assign issue_valid  = (state_q[issuePtr_q] == READY) && (state_q[siblingNum] != BUSY);
  assign unload_num   = unloadPtr_q;
  assign unload_valid = (state_q[unloadPtr_q] == DONE);
  assign busy_count   = busyCount_q;
  assign err          = err_q;

  assign loadFire   = load_valid && load_ready;
  assign issueFire  = issue_valid && issue_ready;
  assign doneFire   = done_valid && doneNumOk && (state_q[done_num] == BUSY);
  assign unloadFire = unload_valid && unload_ready;

  // Each handshake needs a distinct source state, so the four updates never hit the same slot.
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    busyCount_d = busyCount_q;

    if (loadFire)
      state_d[load_num] = READY;
    else if (load_valid)
      err_d = 1'b1;

    if (issueFire)
      state_d[issuePtr_q] = BUSY;

    if (doneFire)
      state_d[done_num] = DONE;
    else if (done_valid)
      err_d = 1'b1;

    if (unloadFire)
      state_d[unloadPtr_q] = EMPTY;

    if (issueFire && !doneFire) begin
      busyCount_d = busyCount_q + 1'b1;
    end else if (doneFire && !issueFire) begin
      if (busyCount_q == '0)
        err_d = 1'b1;
      else
        busyCount_d = busyCount_q - 1'b1;
    end

    issuePtr_d = (issue_valid && !issue_ready) ? issuePtr_q : nextThread(issuePtr_q);

    if (unload_valid && !unload_ready)
      unloadPtr_d = unloadPtr_q;
    else if (unloadPtr_q == TW'(N_THREADS - 1))
      unloadPtr_d = '0;
    else
      unloadPtr_d = unloadPtr_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_THREADS; i++)
        state_q[i] <= EMPTY;
      issuePtr_q  <= '0;
      unloadPtr_q <= '0;
      busyCount_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      issuePtr_q  <= issuePtr_d;
      unloadPtr_q <= unloadPtr_d;
      busyCount_q <= busyCount_d;
      err_q       <= err_d;
    end
  end

endmodule
